// File: rtl/sync_fifo_param_if.sv
// ============================================================================
// Module   : sync_fifo_param_if
// Purpose  : Write/read handshake and status bundle for sync_fifo_param.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sync_fifo_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int SX_W   = 32
);

  logic              wr_cs;
  logic              wr_en;
  logic [DATA_W-1:0] xin;
  logic              rd_cs;
  logic              rd_en;
  logic              flush;
  logic              clr_err;
  logic [DATA_W-1:0] yout;
  logic [SX_W-1:0]   yout_sx;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_cs, wr_en, xin, rd_cs, rd_en, flush, clr_err,
    input  yout, yout_sx, count, empty, full, almost_empty, almost_full,
           overflow, underflow
  );

  modport slave (
    input  wr_cs, wr_en, xin, rd_cs, rd_en, flush, clr_err,
    output yout, yout_sx, count, empty, full, almost_empty, almost_full,
           overflow, underflow
  );

endinterface

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Parametrised synchronous FIFO with fill level, thresholds,
//            optional first-word-fall-through, flush and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_param #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int FWFT      = 0,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1,
  parameter int SX_W      = 32
) (
  input  logic                clk30x,
  input  logic                rst_n,
  sync_fifo_param_if.slave    bus
);

  localparam int              c_DEPTH     = 2 ** ADDR_W;
  localparam int              c_AF_LVL    = c_DEPTH - AF_MARGIN;
  localparam logic [ADDR_W:0] c_CNT_FULL  = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_wr_req;
  logic              w_rd_req;
  logic              w_empty;
  logic              w_full;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic              w_ovf_evt;
  logic              w_udf_evt;
  logic [DATA_W-1:0] w_yout;

  assign w_wr_req = bus.wr_cs & bus.wr_en;
  assign w_rd_req = bus.rd_cs & bus.rd_en;
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_CNT_FULL);

  // A read frees a slot in the same cycle, so a full FIFO still takes a write
  // alongside a read. Flush swallows both requests outright.
  assign w_rd_ok   = ~bus.flush & w_rd_req & ~w_empty;
  assign w_wr_ok   = ~bus.flush & w_wr_req & (~w_full | w_rd_ok);
  assign w_ovf_evt = ~bus.flush & w_wr_req & ~w_wr_ok;
  assign w_udf_evt = ~bus.flush & w_rd_req & ~w_rd_ok;

  always_ff @(posedge clk30x or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk30x) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= bus.xin;
    end
  end

  // A fresh error wins over a simultaneous clear so no event is ever lost.
  always_ff @(posedge clk30x or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_udf_evt) begin
        r_underflow <= 1'b1;
      end else if (bus.clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft_read
      assign w_yout = r_mem[r_rd_ptr];
    end else begin : g_reg_read
      logic [DATA_W-1:0] r_yout;

      always_ff @(posedge clk30x or negedge rst_n) begin
        if (!rst_n) begin
          r_yout <= '0;
        end else if (bus.flush) begin
          r_yout <= '0;
        end else if (w_rd_ok) begin
          r_yout <= r_mem[r_rd_ptr];
        end
      end

      assign w_yout = r_yout;
    end
  endgenerate

  generate
    if (SX_W > DATA_W) begin : g_sx_extend
      assign bus.yout_sx = {{(SX_W-DATA_W){w_yout[DATA_W-1]}}, w_yout};
    end else begin : g_sx_same
      assign bus.yout_sx = w_yout;
    end
  endgenerate

  assign bus.yout         = w_yout;
  assign bus.count        = r_count;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_empty = (int'(r_count) <= AE_MARGIN);
  assign bus.almost_full  = (int'(r_count) >= c_AF_LVL);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Directed checks of sync_fifo_param in registered and FWFT modes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

  logic clk30x;
  logic rst_n;

  int n_checks;
  int n_pass;

  sync_fifo_param_if #(.DATA_W(16), .ADDR_W(3), .SX_W(32)) if0 ();
  sync_fifo_param_if #(.DATA_W(16), .ADDR_W(3), .SX_W(32)) if1 ();

  sync_fifo_param #(
    .DATA_W(16), .ADDR_W(3), .FWFT(0), .AF_MARGIN(1), .AE_MARGIN(1), .SX_W(32)
  ) u_dut_reg (
    .clk30x (clk30x),
    .rst_n  (rst_n),
    .bus    (if0.slave)
  );

  sync_fifo_param #(
    .DATA_W(16), .ADDR_W(3), .FWFT(1), .AF_MARGIN(1), .AE_MARGIN(1), .SX_W(32)
  ) u_dut_fwft (
    .clk30x (clk30x),
    .rst_n  (rst_n),
    .bus    (if1.slave)
  );

  initial begin
    clk30x = 1'b0;
    forever #5 clk30x = ~clk30x;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk30x);
    #1;
  endtask

  task automatic idle_all();
    if0.wr_cs = 0; if0.wr_en = 0; if0.rd_cs = 0; if0.rd_en = 0;
    if0.flush = 0; if0.clr_err = 0;
    if1.wr_cs = 0; if1.wr_en = 0; if1.rd_cs = 0; if1.rd_en = 0;
    if1.flush = 0; if1.clr_err = 0;
  endtask

  task automatic push0(input logic [15:0] d);
    if0.xin = d; if0.wr_cs = 1; if0.wr_en = 1;
    tick();
    if0.wr_cs = 0; if0.wr_en = 0;
  endtask

  task automatic pop0();
    if0.rd_cs = 1; if0.rd_en = 1;
    tick();
    if0.rd_cs = 0; if0.rd_en = 0;
  endtask

  task automatic both0(input logic [15:0] d);
    if0.xin = d; if0.wr_cs = 1; if0.wr_en = 1; if0.rd_cs = 1; if0.rd_en = 1;
    tick();
    if0.wr_cs = 0; if0.wr_en = 0; if0.rd_cs = 0; if0.rd_en = 0;
  endtask

  task automatic clr0();
    if0.clr_err = 1;
    tick();
    if0.clr_err = 0;
  endtask

  task automatic push1(input logic [15:0] d);
    if1.xin = d; if1.wr_cs = 1; if1.wr_en = 1;
    tick();
    if1.wr_cs = 0; if1.wr_en = 0;
  endtask

  task automatic pop1();
    if1.rd_cs = 1; if1.rd_en = 1;
    tick();
    if1.rd_cs = 0; if1.rd_en = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    if0.xin  = '0;
    if1.xin  = '0;
    idle_all();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_yout",   if0.yout, 16'h0000);
    check("rst_count",  if0.count, 4'd0);
    check("rst_empty",  if0.empty, 1'b1);
    check("rst_ae",     if0.almost_empty, 1'b1);
    check("rst_full",   if0.full, 1'b0);
    check("rst_af",     if0.almost_full, 1'b0);
    check("rst_ovf",    if0.overflow, 1'b0);
    check("rst_udf",    if0.underflow, 1'b0);
    check("rst_count1", if1.count, 4'd0);

    // Registered read, two words
    push0(16'h1234);
    check("w1_count", if0.count, 4'd1);
    check("w1_ae",    if0.almost_empty, 1'b1);
    push0(16'h8001);
    check("w2_count", if0.count, 4'd2);
    check("w2_ae",    if0.almost_empty, 1'b0);
    pop0();
    check("r1_yout",  if0.yout, 16'h1234);
    check("r1_sx",    if0.yout_sx, 32'h0000_1234);
    check("r1_count", if0.count, 4'd1);
    pop0();
    check("r2_yout",  if0.yout, 16'h8001);
    check("r2_sx",    if0.yout_sx, 32'hFFFF_8001);
    check("r2_count", if0.count, 4'd0);
    check("r2_empty", if0.empty, 1'b1);

    // Fill to full, overflow, simultaneous read+write while full
    for (int k = 0; k < 8; k++) begin
      push0(16'(k));
      if (k == 5) check("fill6_af", if0.almost_full, 1'b0);
      if (k == 6) begin
        check("fill7_af",   if0.almost_full, 1'b1);
        check("fill7_full", if0.full, 1'b0);
      end
    end
    check("fill8_full",  if0.full, 1'b1);
    check("fill8_count", if0.count, 4'd8);
    push0(16'h0008);
    check("ovf_set",   if0.overflow, 1'b1);
    check("ovf_count", if0.count, 4'd8);
    clr0();
    check("ovf_clr", if0.overflow, 1'b0);
    both0(16'h0009);
    check("fullrw_yout",  if0.yout, 16'h0000);
    check("fullrw_count", if0.count, 4'd8);
    check("fullrw_ovf",   if0.overflow, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      pop0();
      check("drain_yout", if0.yout, (k == 8) ? 16'h0009 : 16'(k));
    end
    check("drain_empty", if0.empty, 1'b1);

    // Pointer wrap-around
    for (int k = 0; k < 12; k++) begin
      push0(16'h00A0 + 16'(k));
      pop0();
      check("wrap_yout", if0.yout, 16'h00A0 + 16'(k));
    end
    check("wrap_ovf", if0.overflow, 1'b0);
    check("wrap_udf", if0.underflow, 1'b0);

    // Underflow handling
    pop0();
    check("udf_set",  if0.underflow, 1'b1);
    check("udf_yout", if0.yout, 16'h00AB);
    clr0();
    check("udf_clr", if0.underflow, 0);
    if0.clr_err = 1;
    pop0();
    if0.clr_err = 0;
    check("udf_clr_vs_new", if0.underflow, 1'b1);
    clr0();

    // Empty with read+write: write wins, read rejected
    both0(16'h0C0C);
    check("emptyrw_count", if0.count, 4'd1);
    check("emptyrw_udf",   if0.underflow, 1'b1);
    check("emptyrw_yout",  if0.yout, 16'h00AB);
    pop0();
    check("emptyrw_data",  if0.yout, 16'h0C0C);
    clr0();

    // Flush with a concurrent write
    for (int k = 0; k < 5; k++) push0(16'h0011 + 16'(k));
    check("pre_flush_count", if0.count, 4'd5);
    if0.flush = 1; if0.xin = 16'h0099; if0.wr_cs = 1; if0.wr_en = 1;
    tick();
    if0.flush = 0; if0.wr_cs = 0; if0.wr_en = 0;
    check("flush_count", if0.count, 4'd0);
    check("flush_empty", if0.empty, 1'b1);
    check("flush_ovf",   if0.overflow, 1'b0);
    check("flush_yout",  if0.yout, 16'h0000);
    push0(16'h0077);
    pop0();
    check("postflush_yout", if0.yout, 16'h0077);

    // First-word-fall-through instance
    push1(16'h5A5A);
    check("fwft_yout",  if1.yout, 16'h5A5A);
    check("fwft_empty", if1.empty, 1'b0);
    pop1();
    check("fwft_rd_empty", if1.empty, 1'b1);
    check("fwft_rd_udf",   if1.underflow, 1'b0);
    push1(16'h9000);
    push1(16'h1111);
    check("fwft_head",    if1.yout, 16'h9000);
    check("fwft_head_sx", if1.yout_sx, 32'hFFFF_9000);
    pop1();
    check("fwft_next",  if1.yout, 16'h1111);
    check("fwft_count", if1.count, 4'd1);

    // Asynchronous reset mid-burst
    push0(16'h0021); push0(16'h0022); push0(16'h0023);
    pop0();
    for (int k = 0; k < 7; k++) push0(16'h0024 + 16'(k));
    check("burst_full", if0.full, 1'b1);
    check("burst_ovf",  if0.overflow, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", if0.count, 4'd0);
    check("arst_empty", if0.empty, 1'b1);
    check("arst_full",  if0.full, 1'b0);
    check("arst_af",    if0.almost_full, 1'b0);
    check("arst_ae",    if0.almost_empty, 1'b1);
    check("arst_yout",  if0.yout, 16'h0000);
    check("arst_ovf",   if0.overflow, 1'b0);
    check("arst_cnt1",  if1.count, 4'd0);
    tick();
    rst_n = 1'b1;
    tick();
    push0(16'h4242);
    pop0();
    check("post_rst_yout",  if0.yout, 16'h4242);
    check("post_rst_count", if0.count, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO that succeeds the fixed 16-bit × 8 syncFifo used in the filterCheby datapath.
- Generic data width and depth; keeps the wr_cs/rd_cs chip-select gating.
- Adds fill count, almost-full/almost-empty thresholds, first-word-fall-through (FWFT) mode, synchronous flush, and sticky overflow/underflow error flags.
- Adds a sign-extended output port so downstream 32-bit accumulators need no external extension logic.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W words
FWFT, 0, 0 = registered read (1-cycle latency), 1 = first-word-fall-through
AF_MARGIN, 1, almost_full asserts when count >= DEPTH-AF_MARGIN
AE_MARGIN, 1, almost_empty asserts when count <= AE_MARGIN
SX_W, 32, width of sign-extended output; must be >= DATA_W

Ports:
clk30x  in  1  single clock; all state updates on its rising edge
rst_n  in  1  asynchronous, active-low reset
wr_cs  in  1  write chip select
wr_en  in  1  write enable; write request = wr_cs & wr_en
xin  in  DATA_W  write data
rd_cs  in  1  read chip select
rd_en  in  1  read enable; read request = rd_cs & rd_en
flush  in  1  synchronous clear of FIFO contents
clr_err  in  1  clears the sticky error flags
yout  out  DATA_W  read data
yout_sx  out  SX_W  yout sign-extended from bit DATA_W-1
count  out  ADDR_W+1  number of stored words, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_empty  out  1  count <= AE_MARGIN
almost_full  out  1  count >= DEPTH-AF_MARGIN
overflow  out  1  sticky; a write request was rejected
underflow  out  1  sticky; a read request was rejected

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers, count, yout, overflow and underflow go to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are don't-care.
- Acceptance:
  - rd_ok = read request & !empty.
  - wr_ok = write request & (!full | rd_ok). When full, a simultaneous read and write both complete and count is unchanged.
  - Empty with both requests: write is accepted, read is rejected, underflow sets (both modes).
- Pointers: ADDR_W-bit write and read pointers; each wraps DEPTH-1 -> 0 on its accepted operation.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- Flags: empty, full, almost_empty and almost_full are decoded combinationally from registered count, so they reflect count after the edge.
- FWFT=0 (registered read):
  - On rd_ok, yout loads mem[rd_ptr] at that edge (data valid the cycle after the request).
  - Otherwise yout holds its value.
- FWFT=1 (fall-through):
  - yout = mem[rd_ptr] combinationally; valid whenever !empty.
  - rd_ok advances rd_ptr to the next word.
  - yout is don't-care while empty.
- yout_sx = {(SX_W-DATA_W) copies of yout[DATA_W-1], yout}, purely combinational.
- Errors:
  - A write request with !wr_ok sets overflow. A read request with !rd_ok sets underflow.
  - Both flags hold until clr_err or reset.
  - If a new error occurs in the same cycle as clr_err, the flag stays set.
- flush:
  - Highest priority after reset. Clears pointers and count; in FWFT=0 also clears yout.
  - Read/write requests in the same cycle are ignored and do not set error flags.
  - Error flags are unaffected by flush.
- Memory: register array of DEPTH × DATA_W, written only on wr_ok. No reset of contents.
- Reset mid-operation: takes effect immediately, independent of clk30x. After deassertion the FIFO is empty and the first accepted write goes to address 0.

Test Plan:
- Reset then idle (DATA_W=16, ADDR_W=3) -> yout=0, count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0.
- FWFT=0:
  - Write 0x1234, 0x8001, then read twice -> yout=0x1234 one cycle after the first read, then 0x8001.
  - At 0x8001: yout_sx=0xFFFF8001. count steps 1,2,1,0.
- Write 8 words 0x0000..0x0007 -> full=1, count=8, almost_full=1 at count 7.
  - 9th write (0x0008) -> overflow=1, count stays 8.
  - Simultaneous read+write while full -> yout=0x0000, count stays 8, no new overflow.
- Wrap-around: 12 write/read pairs of 0x00A0+k with occupancy ≤ 3 -> data returns in order across the pointer wrap, no error flags set.
- Read on empty -> underflow=1, yout unchanged.
  - clr_err pulse -> underflow=0.
  - clr_err together with a new empty read -> underflow stays 1.
- FWFT=1: write 0x5A5A -> yout=0x5A5A with no read issued. Read once -> empty=1.
- flush with count=5 plus a simultaneous write -> count=0, empty=1, no overflow.
  - rst_n pulsed low mid-burst -> all outputs at reset values immediately, before the next clk30x edge.
